// File: rtl/bus_mmu_unit_pkg.sv
// Shared definitions for the bus/MMU unit: bus FSM states, page-table entry
// layout, cpu_status bit positions and address-field widths.
package bus_mmu_unit_pkg;

  // Bus sequencer states
  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_SETUP  = 2'd1,
    BUS_STROBE = 2'd2,
    BUS_DMA    = 2'd3
  } bus_state_e;

  // Address geometry
  localparam int LOGICAL_ADDR_W = 16;
  localparam int PHYS_ADDR_W    = 22;
  localparam int PAGE_OFFSET_W  = 11;
  localparam int FRAME_W        = 11;

  // Page-table entry layout: [10:0] frame, [11] present, [12] io
  localparam int PTE_W              = 13;
  localparam int BITPOS_PTE_PRESENT = 11;
  localparam int BITPOS_PTE_IO      = 12;

  // cpu_status bit carrying the paging enable
  localparam int BITPOS_STATUS_PAGING_EN = 0;

  // Frame number field of a page-table entry
  function automatic logic [FRAME_W-1:0] pte_frame(input logic [PTE_W-1:0] pte);
    return pte[FRAME_W-1:0];
  endfunction

  // Present flag of a page-table entry
  function automatic logic pte_present(input logic [PTE_W-1:0] pte);
    return pte[BITPOS_PTE_PRESENT];
  endfunction

  // I/O-space flag of a page-table entry
  function automatic logic pte_io(input logic [PTE_W-1:0] pte);
    return pte[BITPOS_PTE_IO];
  endfunction

endpackage

// File: rtl/bus_mmu_unit_page_table_ram.sv
// Page-table storage: synchronous write, asynchronous (combinational) read,
// one shared address port. Contents are deliberately not reset.
module bus_mmu_unit_page_table_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  // Store an entry on the write strobe
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/bus_mmu_unit.sv
// Bus/MMU unit: translates the logical MAR address through the on-chip page
// table, sequences read/write strobes with wait states and arbitrates the
// external bus with DMA. Optional wait-state watchdog: define BUS_TIMEOUT_EN.
module bus_mmu_unit
  import bus_mmu_unit_pkg::*;
#(
  parameter int PT_INDEX_W     = 8,   // 6..13
  parameter int STROBE_CYCLES  = 2,   // 1..15
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  input  logic [7:0]  ptb,
  input  logic        paging_en,
  input  logic        user_mode,
  input  logic        force_user_ptb,
  input  logic        pt_we,
  input  logic        pad_wait,
  input  logic        dma_req,
  output logic [21:0] addr,
  output logic        rd,
  output logic        wr,
  output logic        mem_io,
  output logic        dma_ack,
  output logic        busy,
  output logic        done,
  output logic        page_fault,
  output logic        bus_timeout
);

  localparam logic [3:0] STROBE_MIN = 4'(STROBE_CYCLES);

  // Translation path
  logic [7:0]            ptb_sel_s;
  logic [12:0]           pt_idx_full_s;
  logic [PT_INDEX_W-1:0] pt_idx_s;
  logic [PTE_W-1:0]      pte_s;
  logic [21:0]           xlat_addr_s;
  logic                  xlat_io_s;
  logic                  xlat_fault_s;
  logic                  unused_bits_s;

  // Sequencer state
  bus_state_e  state_q, state_d;
  logic [21:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        mem_io_q, mem_io_d;
  logic        dma_ack_q, dma_ack_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        page_fault_q, page_fault_d;
  logic        dir_wr_q, dir_wr_d;
  logic [3:0]  cnt_q, cnt_d;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_q, wait_d;
  logic            bus_timeout_q, bus_timeout_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Supervisor accesses use page-table base 0 unless the user PTB is forced
  assign ptb_sel_s     = (user_mode || force_user_ptb) ? ptb : 8'h00;
  assign pt_idx_full_s = {ptb_sel_s, mar[15:11]};
  assign pt_idx_s      = pt_idx_full_s[PT_INDEX_W-1:0];
  assign unused_bits_s = ^{mdr[15:13], pt_idx_full_s};

  bus_mmu_unit_page_table_ram #(
    .ADDR_W (PT_INDEX_W),
    .DATA_W (PTE_W)
  ) u_pt (
    .clk   (clk),
    .we    (pt_we),
    .addr  (pt_idx_s),
    .wdata (mdr[PTE_W-1:0]),
    .rdata (pte_s)
  );

  // Logical-to-physical translation and fault detection
  always_comb begin
    if (paging_en) begin
      xlat_addr_s  = {pte_frame(pte_s), mar[PAGE_OFFSET_W-1:0]};
      xlat_io_s    = pte_io(pte_s);
      xlat_fault_s = ~pte_present(pte_s);
    end else begin
      xlat_addr_s  = {6'b000000, mar};
      xlat_io_s    = 1'b0;
      xlat_fault_s = 1'b0;
    end
  end

  // Next-state and next-output logic of the bus sequencer
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    mem_io_d     = mem_io_q;
    dma_ack_d    = dma_ack_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    page_fault_d = 1'b0;
    dir_wr_d     = dir_wr_q;
    cnt_d        = cnt_q;
`ifdef BUS_TIMEOUT_EN
    wait_d        = wait_q;
    bus_timeout_d = 1'b0;
`endif
    case (state_q)
      BUS_IDLE: begin
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        dma_ack_d = 1'b0;
        busy_d    = 1'b0;
        if (dma_req) begin
          state_d   = BUS_DMA;
          dma_ack_d = 1'b1;
          addr_d    = 22'd0;
          mem_io_d  = 1'b0;
          busy_d    = req_rd | req_wr;
        end else if (req_rd || req_wr) begin
          // Read wins if both requests are (illegally) raised together
          dir_wr_d = ~req_rd;
          addr_d   = xlat_addr_s;
          mem_io_d = xlat_io_s;
          if (xlat_fault_s) begin
            page_fault_d = 1'b1;
          end else begin
            state_d = BUS_SETUP;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = BUS_IDLE;
        end
      end
      BUS_SETUP: begin
        state_d = BUS_STROBE;
        rd_d    = ~dir_wr_q;
        wr_d    = dir_wr_q;
        cnt_d   = 4'd1;
`ifdef BUS_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      BUS_STROBE: begin
        if ((cnt_q >= STROBE_MIN) && !pad_wait) begin
          state_d = BUS_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
`ifdef BUS_TIMEOUT_EN
        else if (pad_wait && (wait_q == WAIT_LAST)) begin
          state_d       = BUS_IDLE;
          rd_d          = 1'b0;
          wr_d          = 1'b0;
          busy_d        = 1'b0;
          bus_timeout_d = 1'b1;
        end
`endif
        else begin
          // Saturating count keeps long wait states from wrapping
          if (cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            cnt_d = cnt_q;
          end
`ifdef BUS_TIMEOUT_EN
          if (pad_wait) begin
            wait_d = wait_q + TO_W'(1);
          end else begin
            wait_d = wait_q;
          end
`endif
        end
      end
      BUS_DMA: begin
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        addr_d   = 22'd0;
        mem_io_d = 1'b0;
        busy_d   = req_rd | req_wr;
        if (!dma_req) begin
          state_d   = BUS_IDLE;
          dma_ack_d = 1'b0;
        end else begin
          dma_ack_d = 1'b1;
        end
      end
      default: begin
        state_d   = BUS_IDLE;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        dma_ack_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered bus outputs
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= BUS_IDLE;
      addr_q       <= 22'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      mem_io_q     <= 1'b0;
      dma_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      page_fault_q <= 1'b0;
      dir_wr_q     <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      mem_io_q     <= mem_io_d;
      dma_ack_q    <= dma_ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      page_fault_q <= page_fault_d;
      dir_wr_q     <= dir_wr_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Wait-state watchdog counter and its abort pulse
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wait_q        <= '0;
      bus_timeout_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end
  assign bus_timeout = bus_timeout_q;
`else
  assign bus_timeout = 1'b0;
`endif

  assign addr       = addr_q;
  assign rd         = rd_q;
  assign wr         = wr_q;
  assign mem_io     = mem_io_q;
  assign dma_ack    = dma_ack_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign page_fault = page_fault_q;

endmodule

// File: tb/tb_bus_mmu_unit.sv
// Directed bench for bus_mmu_unit: translation, strobe timing, wait states,
// page faults, DMA arbitration, async reset and (with BUS_TIMEOUT_EN) the
// wait-state watchdog.
module tb_bus_mmu_unit;

  logic        clk, arst, req_rd, req_wr;
  logic [15:0] mar, mdr;
  logic [7:0]  ptb;
  logic        paging_en, user_mode, force_user_ptb, pt_we, pad_wait, dma_req;
  logic [21:0] addr;
  logic        rd, wr, mem_io, dma_ack, busy, done, page_fault, bus_timeout;

  int n_cmp = 0;
  int n_err = 0;

  bus_mmu_unit #(
    .PT_INDEX_W     (8),
    .STROBE_CYCLES  (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .arst           (arst),
    .req_rd         (req_rd),
    .req_wr         (req_wr),
    .mar            (mar),
    .mdr            (mdr),
    .ptb            (ptb),
    .paging_en      (paging_en),
    .user_mode      (user_mode),
    .force_user_ptb (force_user_ptb),
    .pt_we          (pt_we),
    .pad_wait       (pad_wait),
    .dma_req        (dma_req),
    .addr           (addr),
    .rd             (rd),
    .wr             (wr),
    .mem_io         (mem_io),
    .dma_ack        (dma_ack),
    .busy           (busy),
    .done           (done),
    .page_fault     (page_fault),
    .bus_timeout    (bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pt_write(input logic [7:0] p, input logic um,
                          input logic [15:0] m, input logic [15:0] d);
    ptb = p; user_mode = um; force_user_ptb = 1'b0; mar = m; mdr = d;
    pt_we = 1'b1;
    tick();
    pt_we = 1'b0;
  endtask

  // Run until done (bounded), counting cycles with rd / wr high
  task automatic run_to_done(output int rdc, output int wrc, output bit seen);
    rdc = 0; wrc = 0; seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (rd) rdc++;
      if (wr) wrc++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; mar = 16'h0000; mdr = 16'h0000;
    ptb = 8'h00; paging_en = 1'b0; user_mode = 1'b0; force_user_ptb = 1'b0;
    pt_we = 1'b0; pad_wait = 1'b0; dma_req = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({rd, wr, mem_io, dma_ack, busy, done, page_fault, bus_timeout} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {rd, wr, mem_io, dma_ack, busy, done, page_fault, bus_timeout});
    end
    n_cmp++;
    if (addr !== 22'd0) begin
      n_err++; $display("FAIL reset_addr: got %h expected 000000", addr);
    end
    @(negedge clk) arst = 1'b0;
    tick();
    n_cmp++;
    if ({rd, wr, busy, done} !== 4'b0000) begin
      n_err++; $display("FAIL idle_after_reset: got %b expected 0000", {rd, wr, busy, done});
    end
  endtask

  task automatic test_unpaged_read();
    paging_en = 1'b0; mar = 16'h1234; req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    n_cmp++;
    if ({busy, rd, mem_io} !== 3'b100 || addr !== 22'h001234) begin
      n_err++; $display("FAIL unpaged_setup: got busy/rd/io=%b addr=%h expected 100 001234",
                        {busy, rd, mem_io}, addr);
    end
    tick();
    n_cmp++;
    if ({rd, wr, done} !== 3'b100) begin
      n_err++; $display("FAIL unpaged_strobe1: got %b expected 100", {rd, wr, done});
    end
    tick();
    n_cmp++;
    if ({rd, done} !== 2'b10) begin
      n_err++; $display("FAIL unpaged_strobe2: got %b expected 10", {rd, done});
    end
    tick();
    n_cmp++;
    if ({rd, done, busy} !== 3'b010) begin
      n_err++; $display("FAIL unpaged_done: got rd/done/busy=%b expected 010", {rd, done, busy});
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL unpaged_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_paged_write();
    int rdc, wrc; bit seen;
    pt_write(8'h01, 1'b1, 16'h1005, 16'h1ABC);
    paging_en = 1'b1; user_mode = 1'b1; ptb = 8'h01; mar = 16'h1005; req_wr = 1'b1;
    tick();
    req_wr = 1'b0;
    n_cmp++;
    if (addr !== 22'h15E005 || mem_io !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL paged_write_xlat: got addr=%h io=%b busy=%b expected 15e005 1 1",
                        addr, mem_io, busy);
    end
    run_to_done(rdc, wrc, seen);
    n_cmp++;
    if (!seen || wrc != 2 || rdc != 0) begin
      n_err++; $display("FAIL paged_write_strobe: got done=%0d wr=%0d rd=%0d expected 1 2 0",
                        seen, wrc, rdc);
    end
  endtask

  task automatic test_page_fault();
    bit bad;
    pt_write(8'h01, 1'b1, 16'h1800, 16'h0123);
    paging_en = 1'b1; user_mode = 1'b1; ptb = 8'h01; mar = 16'h1800; req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    n_cmp++;
    if ({page_fault, busy, rd} !== 3'b100) begin
      n_err++; $display("FAIL fault_pulse: got pf/busy/rd=%b expected 100", {page_fault, busy, rd});
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rd || busy || page_fault || done) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++; $display("FAIL fault_quiet: got activity=%b expected 0", bad);
    end
  endtask

  task automatic test_ptb_select();
    int rdc, wrc; bit seen;
    pt_write(8'h01, 1'b0, 16'h1005, 16'h0955);
    user_mode = 1'b0; force_user_ptb = 1'b0; ptb = 8'h01; paging_en = 1'b1;
    mar = 16'h1005; req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    n_cmp++;
    if (addr !== 22'h0AA805 || mem_io !== 1'b0) begin
      n_err++; $display("FAIL ptb_supervisor: got addr=%h io=%b expected 0aa805 0", addr, mem_io);
    end
    run_to_done(rdc, wrc, seen);
    force_user_ptb = 1'b1; req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    n_cmp++;
    if (addr !== 22'h15E005 || mem_io !== 1'b1) begin
      n_err++; $display("FAIL ptb_forced: got addr=%h io=%b expected 15e005 1", addr, mem_io);
    end
    run_to_done(rdc, wrc, seen);
    n_cmp++;
    if (!seen || rdc != 2) begin
      n_err++; $display("FAIL ptb_forced_done: got done=%0d rd=%0d expected 1 2", seen, rdc);
    end
    force_user_ptb = 1'b0; user_mode = 1'b0; paging_en = 1'b0;
  endtask

  task automatic test_wait_states();
    int cnt; bit early;
    paging_en = 1'b0; mar = 16'h0042; req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    cnt = 0; early = 1'b0;
    tick(); if (rd) cnt++;
    tick(); if (rd) cnt++;
    pad_wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rd) cnt++;
      if (done || bus_timeout) early = 1'b1;
    end
    pad_wait = 1'b0;
    tick();
    n_cmp++;
    if (cnt != 7 || early) begin
      n_err++; $display("FAIL wait_rd_len: got rd=%0d early_end=%b expected 7 0", cnt, early);
    end
    n_cmp++;
    if ({rd, done} !== 2'b01) begin
      n_err++; $display("FAIL wait_done: got rd/done=%b expected 01", {rd, done});
    end
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    int cnt, to_cnt; bit saw_done; int rdc, wrc; bit seen;
    paging_en = 1'b0; mar = 16'h0055; req_rd = 1'b1;
    tick();
    req_rd = 1'b0; pad_wait = 1'b1;
    cnt = 0; to_cnt = 0; saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd) cnt++;
      if (bus_timeout) to_cnt++;
      if (done) saw_done = 1'b1;
    end
    pad_wait = 1'b0;
    n_cmp++;
    if (cnt != 8 || to_cnt != 1 || saw_done) begin
      n_err++; $display("FAIL timeout_abort: got rd=%0d pulses=%0d done=%b expected 8 1 0",
                        cnt, to_cnt, saw_done);
    end
    mar = 16'h0056; req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    run_to_done(rdc, wrc, seen);
    n_cmp++;
    if (!seen || rdc != 2) begin
      n_err++; $display("FAIL timeout_recover: got done=%0d rd=%0d expected 1 2", seen, rdc);
    end
  endtask
`endif

  task automatic test_dma();
    int rdc, wrc; bit seen;
    paging_en = 1'b0; mar = 16'h0777; req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    tick();
    dma_req = 1'b1;
    tick();
    n_cmp++;
    if ({rd, dma_ack} !== 2'b10) begin
      n_err++; $display("FAIL dma_defer: got rd/ack=%b expected 10", {rd, dma_ack});
    end
    tick();
    n_cmp++;
    if ({rd, done, dma_ack} !== 3'b010) begin
      n_err++; $display("FAIL dma_cycle_first: got rd/done/ack=%b expected 010", {rd, done, dma_ack});
    end
    tick();
    n_cmp++;
    if ({dma_ack, busy, rd} !== 3'b100 || addr !== 22'd0) begin
      n_err++; $display("FAIL dma_grant: got ack/busy/rd=%b addr=%h expected 100 000000",
                        {dma_ack, busy, rd}, addr);
    end
    mar = 16'h0888; req_rd = 1'b1;
    tick();
    n_cmp++;
    if ({dma_ack, busy, rd} !== 3'b110) begin
      n_err++; $display("FAIL dma_hold_req: got ack/busy/rd=%b expected 110", {dma_ack, busy, rd});
    end
    dma_req = 1'b0;
    tick();
    n_cmp++;
    if ({dma_ack, busy, rd} !== 3'b010) begin
      n_err++; $display("FAIL dma_release: got ack/busy/rd=%b expected 010", {dma_ack, busy, rd});
    end
    tick();
    req_rd = 1'b0;
    n_cmp++;
    if (addr !== 22'h000888 || busy !== 1'b1) begin
      n_err++; $display("FAIL dma_then_read: got addr=%h busy=%b expected 000888 1", addr, busy);
    end
    run_to_done(rdc, wrc, seen);
    n_cmp++;
    if (!seen || rdc != 2) begin
      n_err++; $display("FAIL dma_then_read_done: got done=%0d rd=%0d expected 1 2", seen, rdc);
    end
  endtask

  task automatic test_back_to_back();
    int rdc, wrc; bit seen;
    paging_en = 1'b0; mar = 16'h00AB; req_rd = 1'b1; req_wr = 1'b1;
    tick();
    req_rd = 1'b0; req_wr = 1'b0;
    run_to_done(rdc, wrc, seen);
    n_cmp++;
    if (!seen || rdc != 2 || wrc != 0) begin
      n_err++; $display("FAIL read_wins: got done=%0d rd=%0d wr=%0d expected 1 2 0", seen, rdc, wrc);
    end
    mar = 16'h00CD; req_wr = 1'b1;
    tick();
    req_wr = 1'b0;
    n_cmp++;
    if (addr !== 22'h0000CD || busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_latch: got addr=%h busy=%b expected 0000cd 1", addr, busy);
    end
    run_to_done(rdc, wrc, seen);
    n_cmp++;
    if (!seen || wrc != 2 || rdc != 0) begin
      n_err++; $display("FAIL b2b_write: got done=%0d wr=%0d rd=%0d expected 1 2 0", seen, wrc, rdc);
    end
  endtask

  task automatic test_async_reset();
    bit bad; int rdc, wrc; bit seen;
    paging_en = 1'b0; mar = 16'h0100; req_wr = 1'b1;
    tick();
    req_wr = 1'b0;
    tick();
    #2 arst = 1'b1;
    #1;
    n_cmp++;
    if ({wr, busy} !== 2'b00 || addr !== 22'd0) begin
      n_err++; $display("FAIL async_reset_drop: got wr/busy=%b addr=%h expected 00 000000",
                        {wr, busy}, addr);
    end
    @(negedge clk) arst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || wr) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++; $display("FAIL async_reset_no_done: got activity=%b expected 0", bad);
    end
    req_rd = 1'b1;
    tick();
    req_rd = 1'b0;
    run_to_done(rdc, wrc, seen);
    n_cmp++;
    if (!seen || rdc != 2) begin
      n_err++; $display("FAIL async_reset_recover: got done=%0d rd=%0d expected 1 2", seen, rdc);
    end
  endtask

  initial begin
    test_reset();
    test_unpaged_read();
    test_paged_write();
    test_page_fault();
    test_ptb_select();
    test_wait_states();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_dma();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
